reg_file_ctrl: RTL and testbench
================================

// Module: reg_file_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the reg_file write and read ports. Shares the single
//  write port between a user requester (switches + debounced button) and an internal
//  CLEAR sequencer; drives the read port from a user address or an auto-SCAN counter.
//  Sits between the board I/O and reg_file; disp_* feeds hex2sseg / display logic.
// PARAMETERS
//  N       3   address width; register file depth = 2**N
//  BITS    4   data width
//  DWELL   2   clock cycles each address is held during SCAN (>=1)
//  CLR_VAL 0   BITS-wide value written to every location by CLEAR
// PORTS
//  clk         in   1     system clock, all state on rising edge
//  reset       in   1     asynchronous, active-high; clears all state
//  clr_start   in   1     1-cycle pulse: start CLEAR sequence
//  scan_start  in   1     1-cycle pulse: start SCAN
//  scan_stop   in   1     1-cycle pulse: end SCAN
//  usr_wr_req  in   1     user write request, level, held until usr_wr_ack
//  usr_addr    in   N     user write address
//  usr_data    in   BITS  user write data
//  usr_rd_addr in   N     read address used in IDLE
//  usr_wr_ack  out  1     1-cycle pulse, same cycle as the granted rf_we
//  rf_we       out  1     reg_file write enable
//  rf_addr_w   out  N     reg_file write address
//  rf_data_w   out  BITS  reg_file write data
//  rf_addr_r   out  N     reg_file read address
//  rf_data_r   in   BITS  reg_file read data (combinational w.r.t. rf_addr_r)
//  disp_addr   out  N     registered address being displayed
//  disp_data   out  BITS  registered data for disp_addr
//  busy        out  1     1 while in CLEAR
//  done        out  1     1-cycle pulse on CLEAR completion
// BEHAVIOUR
//  - Reset: state=IDLE; all counters 0; rf_we, usr_wr_ack, busy, done = 0; rf_addr_w,
//    rf_data_w, rf_addr_r, disp_addr, disp_data = 0; usr request armed.
//  - States: IDLE, CLEAR, SCAN. rf_* write outputs are combinational from state/inputs.
//  - IDLE: rf_addr_r=usr_rd_addr. clr_start->CLEAR (wins if scan_start same cycle);
//    scan_start->SCAN with scan counter=0, dwell counter=0.
//  - CLEAR: cnt 0..2**N-1, one write per cycle: rf_we=1, rf_addr_w=cnt,
//    rf_data_w=CLR_VAL; exactly 2**N cycles; busy=1 throughout. Last write cycle:
//    next state IDLE, done=1 the following cycle. scan_start, scan_stop, clr_start ignored.
//  - SCAN: rf_addr_r=scan counter; address held DWELL cycles then increments, wraps
//    2**N-1 -> 0, runs until scan_stop (->IDLE next cycle). clr_start aborts -> CLEAR;
//    clr_start and scan_stop same cycle -> CLEAR.
//  - Display: every cycle, all states, disp_addr<=rf_addr_r, disp_data<=rf_data_r
//    (1-cycle latency). During CLEAR rf_addr_r=usr_rd_addr.
//  - User write arbitration: CLEAR has priority. In IDLE or SCAN, usr_wr_req high and
//    armed -> rf_we=1, rf_addr_w=usr_addr, rf_data_w=usr_data, usr_wr_ack=1 same
//    cycle; armed cleared. Re-arms only after usr_wr_req is sampled low (one write per
//    request level). Request during CLEAR stalls (no ack); granted first cycle after.
//  - Request arriving the cycle CLEAR is entered is stalled, not granted.
//  - A user write to the address being scanned shows on disp_data 1 cycle after write
//    (reg_file write-before-read on next edge).
//  - Reset asserted mid-CLEAR/SCAN: immediate return to reset values; CLEAR is not
//    resumed; done not pulsed.
// TESTING (N=3, BITS=4, DWELL=2, CLR_VAL=0)
//  1 Preload 1..8 via user writes, clr_start -> rf_we high 8 consecutive cycles,
//    addr 0..7, data 0; busy 8 cycles; done 1 cycle; reads of all 8 return 0.
//  2 Mem[i]=i+1, scan_start -> disp_addr 0,0,1,1,..,7,7,0,0 (wraps), disp_data =
//    disp_addr+1; scan_stop -> IDLE, disp_addr follows usr_rd_addr.
//  3 usr_wr_req held 5 cycles, addr=5, data=A -> exactly one ack and one write;
//    drop and reassert -> second write.
//  4 usr_wr_req asserted at CLEAR cycle 3 -> no ack until CLEAR ends; granted the
//    cycle after last clear write; final mem[addr]=usr_data, not CLR_VAL.
//  5 clr_start and scan_start same IDLE cycle -> CLEAR only; clr_start mid-SCAN ->
//    CLEAR starts at addr 0 next cycle.
//  6 reset pulse at CLEAR cycle 4 -> all outputs 0 immediately, state IDLE, no done;
//    mem[4..7] keep prior values.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// Write-port arbiter and read-port sequencer in front of a register file.
// A CLEAR sequencer has priority over the user writer, and an auto-SCAN walks the read address.
module reg_file_ctrl #(
    parameter int unsigned N                 = 3,
    parameter int unsigned BITS              = 4,
    parameter int unsigned DWELL             = 2,
    parameter logic [BITS-1:0] CLR_VAL       = {BITS{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_start,
    input  logic            scan_start,
    input  logic            scan_stop,
    input  logic            usr_wr_req,
    input  logic [N-1:0]    usr_addr,
    input  logic [BITS-1:0] usr_data,
    input  logic [N-1:0]    usr_rd_addr,
    output logic            usr_wr_ack,
    output logic            rf_we,
    output logic [N-1:0]    rf_addr_w,
    output logic [BITS-1:0] rf_data_w,
    output logic [N-1:0]    rf_addr_r,
    input  logic [BITS-1:0] rf_data_r,
    output logic [N-1:0]    disp_addr,
    output logic [BITS-1:0] disp_data,
    output logic            busy,
    output logic            done
);

    localparam int unsigned DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N-1:0] LAST = {N{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SCAN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_cnt;
    logic [N-1:0]    r_scan;
    logic [DW-1:0]   r_dwell;
    logic            r_armed;
    logic            r_done;
    logic [N-1:0]    r_disp_addr;
    logic [BITS-1:0] r_disp_data;

    logic            w_grant;
    logic            w_we;
    logic [N-1:0]    w_addr_w;
    logic [BITS-1:0] w_data_w;
    logic [N-1:0]    w_addr_r;

    // Port muxing; a user request is not granted on the cycle a CLEAR is being launched.
    always_comb begin
        w_grant  = 1'b0;
        w_we     = 1'b0;
        w_addr_w = {N{1'b0}};
        w_data_w = {BITS{1'b0}};
        w_addr_r = {N{1'b0}};
        if (reset) begin
            w_grant = 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    w_we     = 1'b1;
                    w_addr_w = r_cnt;
                    w_data_w = CLR_VAL;
                    w_addr_r = usr_rd_addr;
                end
                S_SCAN: begin
                    w_grant  = usr_wr_req && r_armed && !clr_start;
                    w_addr_r = r_scan;
                end
                default: begin
                    w_grant  = usr_wr_req && r_armed && !clr_start;
                    w_addr_r = usr_rd_addr;
                end
            endcase
            if (w_grant) begin
                w_we     = 1'b1;
                w_addr_w = usr_addr;
                w_data_w = usr_data;
            end else begin
                w_we     = w_we;
            end
        end
    end

    // Sequencer state, request arming, completion pulse and display capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= {N{1'b0}};
            r_scan      <= {N{1'b0}};
            r_dwell     <= {DW{1'b0}};
            r_armed     <= 1'b1;
            r_done      <= 1'b0;
            r_disp_addr <= {N{1'b0}};
            r_disp_data <= {BITS{1'b0}};
        end else begin
            r_disp_addr <= w_addr_r;
            r_disp_data <= rf_data_r;
            r_done      <= (r_state == S_CLEAR) && (r_cnt == LAST);
            if (w_grant) begin
                r_armed <= 1'b0;
            end else if (!usr_wr_req) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= {N{1'b0}};
                    end else if (scan_start) begin
                        r_state <= S_SCAN;
                        r_scan  <= {N{1'b0}};
                        r_dwell <= {DW{1'b0}};
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= {N{1'b0}};
                    end else begin
                        r_cnt   <= r_cnt + N'(1);
                    end
                end
                S_SCAN: begin
                    if (clr_start) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= {N{1'b0}};
                    end else if (scan_stop) begin
                        r_state <= S_IDLE;
                    end else if (r_dwell == DW'(DWELL - 1)) begin
                        r_dwell <= {DW{1'b0}};
                        r_scan  <= r_scan + N'(1);
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign usr_wr_ack = w_grant;
    assign rf_we      = w_we;
    assign rf_addr_w  = w_addr_w;
    assign rf_data_w  = w_data_w;
    assign rf_addr_r  = w_addr_r;
    assign disp_addr  = r_disp_addr;
    assign disp_data  = r_disp_data;
    assign busy       = (r_state == S_CLEAR);
    assign done       = r_done;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: a register-file model, a per-cycle behavioural reference,
// directed scenarios with literal expectations, then a randomized phase.
module tb_reg_file_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_start, scan_start, scan_stop, usr_wr_req;
    logic [2:0] usr_addr, usr_rd_addr;
    logic [3:0] usr_data;
    logic       usr_wr_ack, rf_we, busy, done;
    logic [2:0] rf_addr_w, rf_addr_r, disp_addr;
    logic [3:0] rf_data_w, rf_data_r, disp_data;

    logic [3:0] tb_mem [8];
    int total = 0;
    int bad   = 0;

    reg_file_ctrl #(.N(3), .BITS(4), .DWELL(2), .CLR_VAL(4'h0)) dut (
        .clk(clk), .reset(reset), .clr_start(clr_start), .scan_start(scan_start),
        .scan_stop(scan_stop), .usr_wr_req(usr_wr_req), .usr_addr(usr_addr),
        .usr_data(usr_data), .usr_rd_addr(usr_rd_addr), .usr_wr_ack(usr_wr_ack),
        .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .rf_addr_r(rf_addr_r), .rf_data_r(rf_data_r), .disp_addr(disp_addr),
        .disp_data(disp_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Register file seen by the DUT: combinational read, write on the rising edge.
    assign rf_data_r = tb_mem[rf_addr_r];
    always @(posedge clk) begin
        if (rf_we) tb_mem[rf_addr_w] <= rf_data_w;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=clear 2=scan, scan address derived from elapsed cycles.
    int m_mode = 0, m_idx = 0, m_t = 0;
    bit m_served = 0, m_done = 0;
    int m_dispa = 0, m_dispd = 0;
    int exp_mem [8];
    bit e_we = 0, e_grant = 0;
    int e_aw = 0, e_dw = 0, e_ar = 0;

    // Compare process: derive this cycle's expected outputs and check every DUT output.
    always @(negedge clk) begin
        e_we = 0; e_grant = 0; e_aw = 0; e_dw = 0; e_ar = 0;
        if (!reset) begin
            if (m_mode == 1) begin
                e_we = 1; e_aw = m_idx; e_dw = 0; e_ar = usr_rd_addr;
            end else begin
                e_grant = usr_wr_req && !m_served && !clr_start;
                e_we = e_grant;
                e_aw = e_grant ? int'(usr_addr) : 0;
                e_dw = e_grant ? int'(usr_data) : 0;
                e_ar = (m_mode == 2) ? (m_t / 2) % 8 : int'(usr_rd_addr);
            end
        end
        chk("rf_we", rf_we, e_we);
        chk("rf_addr_w", rf_addr_w, e_aw);
        chk("rf_data_w", rf_data_w, e_dw);
        chk("rf_addr_r", rf_addr_r, e_ar);
        chk("usr_wr_ack", usr_wr_ack, e_grant);
        chk("busy", busy, (!reset && m_mode == 1) ? 1 : 0);
        chk("done", done, (!reset && m_done) ? 1 : 0);
        chk("disp_addr", disp_addr, reset ? 0 : m_dispa);
        chk("disp_data", disp_data, reset ? 0 : m_dispd);
    end

    // Model advance on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_idx = 0; m_t = 0; m_served = 0; m_done = 0;
            m_dispa = 0; m_dispd = 0;
        end else begin
            m_dispa = e_ar;
            m_dispd = exp_mem[e_ar];
            if (e_we) exp_mem[e_aw] = e_dw;
            m_done = (m_mode == 1 && m_idx == 7);
            if (e_grant) m_served = 1;
            else if (!usr_wr_req) m_served = 0;
            case (m_mode)
                1: begin
                    if (m_idx == 7) begin m_mode = 0; m_idx = 0; end
                    else m_idx++;
                end
                2: begin
                    if (clr_start) begin m_mode = 1; m_idx = 0; end
                    else if (scan_stop) m_mode = 0;
                    else m_t++;
                end
                default: begin
                    if (clr_start) begin m_mode = 1; m_idx = 0; end
                    else if (scan_start) begin m_mode = 2; m_t = 0; end
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) begin
            usr_addr = 3'(i); usr_data = 4'(i + 1); usr_wr_req = 1'b1;
            step();
            usr_wr_req = 1'b0;
            step();
        end
    endtask

    task automatic pulse_clr();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
    endtask

    int n_busy, n_done, n_ack;

    initial begin
        for (int i = 0; i < 8; i++) begin tb_mem[i] = 4'h0; exp_mem[i] = 0; end
        reset = 1'b1; clr_start = 1'b0; scan_start = 1'b0; scan_stop = 1'b0;
        usr_wr_req = 1'b0; usr_addr = 3'd0; usr_data = 4'd0; usr_rd_addr = 3'd0;
        repeat (2) step();
        @(negedge clk);
        chk("reset_disp_addr", disp_addr, 0);
        chk("reset_we", rf_we, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step();

        // Preload then CLEAR: 8 busy cycles, one done, memory reads zero.
        preload();
        chk("preload_mem6", tb_mem[6], 7);
        clr_start = 1'b1;
        n_busy = 0; n_done = 0;
        for (int c = 0; c < 11; c++) begin
            step();
            clr_start = 1'b0;
            @(negedge clk);
            if (busy) n_busy++;
            if (done) n_done++;
        end
        chk("clear_busy_cycles", n_busy, 8);
        chk("clear_done_pulses", n_done, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            usr_rd_addr = 3'(i);
            @(negedge clk);
            chk("clear_read", rf_data_r, 0);
            step();
            @(negedge clk);
            chk("clear_disp", disp_data, 0);
        end
        step();

        // SCAN with DWELL 2 over mem[i]=i+1, including wrap.
        preload();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        step();
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk("scan_disp_addr", disp_addr, (k / 2) % 8);
            chk("scan_disp_data", disp_data, (k / 2) % 8 + 1);
            step();
        end
        scan_stop = 1'b1;
        step();
        scan_stop = 1'b0;
        usr_rd_addr = 3'd3;
        step();
        @(negedge clk);
        chk("post_scan_disp", disp_addr, 3);
        step();

        // Held request: one write per request level.
        usr_addr = 3'd5; usr_data = 4'hA; usr_wr_req = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (usr_wr_ack) n_ack++;
            step();
        end
        chk("held_req_acks", n_ack, 1);
        usr_wr_req = 1'b0;
        step();
        usr_wr_req = 1'b1;
        @(negedge clk);
        chk("reassert_ack", usr_wr_ack, 1);
        step();
        usr_wr_req = 1'b0;
        step();
        chk("held_req_mem5", tb_mem[5], 10);

        // Request raised mid-CLEAR stalls, then wins over the cleared value.
        pulse_clr();
        repeat (3) step();
        usr_addr = 3'd2; usr_data = 4'h9; usr_wr_req = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (usr_wr_ack) n_ack++;
            step();
        end
        chk("stall_acks", n_ack, 0);
        @(negedge clk);
        chk("post_clear_grant", usr_wr_ack, 1);
        step();
        usr_wr_req = 1'b0;
        step();
        chk("stall_mem2", tb_mem[2], 9);

        // CLEAR beats a simultaneous scan_start, and aborts a running SCAN.
        clr_start = 1'b1; scan_start = 1'b1;
        step();
        clr_start = 1'b0; scan_start = 1'b0;
        @(negedge clk);
        chk("clr_wins_busy", busy, 1);
        repeat (9) step();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        repeat (3) step();
        pulse_clr();
        @(negedge clk);
        chk("abort_busy", busy, 1);
        chk("abort_addr0", rf_addr_w, 0);
        repeat (9) step();

        // Reset during CLEAR cycle 4 leaves the upper half untouched.
        preload();
        pulse_clr();
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", busy, 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 8; i++)
            chk("mid_reset_mem", tb_mem[i], (i < 4) ? 0 : i + 1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            clr_start   = ($urandom_range(0, 39) == 0);
            scan_start  = ($urandom_range(0, 14) == 0);
            scan_stop   = ($urandom_range(0, 29) == 0);
            usr_rd_addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) begin
                usr_wr_req = ~usr_wr_req;
                usr_addr   = 3'($urandom_range(0, 7));
                usr_data   = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; clr_start = 1'b0; scan_start = 1'b0; scan_stop = 1'b0;
        usr_wr_req = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
